// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: parametrised UART transmitter with ready/valid input.
// Frame = start bit, DATA_BITS data bits LSB first, optional parity bit, 1 or 2 stop bits.
// Each serial bit lasts exactly CLK_DIV clock cycles; txd is a registered output.
module uart_tx_cfg #(
    parameter int CLK_DIV    = 501,
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 txd,
    output logic                 tx_busy,
    output logic                 tx_done
);

    if (CLK_DIV < 2 || CLK_DIV > 65535) begin : g_bad_clk_div
        $error("uart_tx_cfg: CLK_DIV must be in 2..65535");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_cfg: DATA_BITS must be in 5..9");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
    end
    if (PARITY_EN != 0 && PARITY_EN != 1) begin : g_bad_parity_en
        $error("uart_tx_cfg: PARITY_EN must be 0 or 1");
    end
    if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity_odd
        $error("uart_tx_cfg: PARITY_ODD must be 0 or 1");
    end

    localparam int              BW        = $clog2(CLK_DIV);
    localparam logic [BW-1:0]   BAUD_LAST = BW'(CLK_DIV - 1);
    localparam logic [3:0]      DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]      STOP_LAST = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               state_q, state_d;
    logic [BW-1:0]        baud_q, baud_d;
    logic [3:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] shift_nxt;
    logic                 par_q, par_d;
    logic                 txd_q, txd_d;
    logic                 done_q, done_d;
    logic                 bit_end;
    logic                 accept;

    assign bit_end   = (baud_q == BAUD_LAST);
    assign accept    = tx_valid && tx_ready;
    assign shift_nxt = {1'b0, shift_q[DATA_BITS-1:1]};

    // Next-state, counters and next serial level; txd_d is the level for the coming bit
    // so that the registered txd changes on the same edge as the state.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        txd_d   = txd_q;
        done_d  = 1'b0;

        if (state_q != S_IDLE) begin
            baud_d = bit_end ? '0 : baud_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                baud_d = '0;
                bit_d  = '0;
                txd_d  = 1'b1;
                if (accept) begin
                    state_d = S_START;
                    shift_d = tx_data;
                    // Parity is taken from the latched word because the shifter empties out.
                    par_d   = (^tx_data) ^ (PARITY_ODD != 0);
                    txd_d   = 1'b0;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    bit_d   = '0;
                    txd_d   = shift_q[0];
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    shift_d = shift_nxt;
                    if (bit_q == DATA_LAST) begin
                        bit_d = '0;
                        if (PARITY_EN != 0) begin
                            state_d = S_PARITY;
                            txd_d   = par_q;
                        end else begin
                            state_d = S_STOP;
                            txd_d   = 1'b1;
                        end
                    end else begin
                        bit_d = bit_q + 4'd1;
                        txd_d = shift_nxt[0];
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                    bit_d   = '0;
                    txd_d   = 1'b1;
                end
            end
            S_STOP: begin
                txd_d = 1'b1;
                if (bit_end) begin
                    if (bit_q == STOP_LAST) begin
                        state_d = S_IDLE;
                        bit_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                baud_d  = '0;
                bit_d   = '0;
                txd_d   = 1'b1;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            txd_q   <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            txd_q   <= txd_d;
            done_q  <= done_d;
        end
    end

    assign txd      = txd_q;
    assign tx_done  = done_q;
    assign tx_busy  = (state_q != S_IDLE);
    assign tx_ready = (state_q == S_IDLE) && !reset;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg: five transmitter configurations checked cycle by cycle against a
// frame model built from the word, the parameter set and the bit period.
module tb_uart_tx_cfg;

    localparam int N = 5;
    localparam int P_DIV [N] = '{4, 4, 4, 4, 2};
    localparam int P_DB  [N] = '{8, 8, 8, 7, 9};
    localparam int P_PE  [N] = '{0, 1, 1, 0, 1};
    localparam int P_ODD [N] = '{0, 0, 1, 0, 1};
    localparam int P_SB  [N] = '{1, 1, 1, 2, 2};

    logic       clk;
    logic       reset;
    logic       tx_valid [N];
    logic [8:0] tx_data  [N];
    logic       tx_ready [N];
    logic       txd      [N];
    logic       tx_busy  [N];
    logic       tx_done  [N];

    int checks   = 0;
    int failures = 0;

    uart_tx_cfg #(.CLK_DIV(4), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u0 (
        .clk(clk), .reset(reset), .tx_valid(tx_valid[0]), .tx_data(tx_data[0][7:0]),
        .tx_ready(tx_ready[0]), .txd(txd[0]), .tx_busy(tx_busy[0]), .tx_done(tx_done[0]));
    uart_tx_cfg #(.CLK_DIV(4), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u1 (
        .clk(clk), .reset(reset), .tx_valid(tx_valid[1]), .tx_data(tx_data[1][7:0]),
        .tx_ready(tx_ready[1]), .txd(txd[1]), .tx_busy(tx_busy[1]), .tx_done(tx_done[1]));
    uart_tx_cfg #(.CLK_DIV(4), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u2 (
        .clk(clk), .reset(reset), .tx_valid(tx_valid[2]), .tx_data(tx_data[2][7:0]),
        .tx_ready(tx_ready[2]), .txd(txd[2]), .tx_busy(tx_busy[2]), .tx_done(tx_done[2]));
    uart_tx_cfg #(.CLK_DIV(4), .DATA_BITS(7), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u3 (
        .clk(clk), .reset(reset), .tx_valid(tx_valid[3]), .tx_data(tx_data[3][6:0]),
        .tx_ready(tx_ready[3]), .txd(txd[3]), .tx_busy(tx_busy[3]), .tx_done(tx_done[3]));
    uart_tx_cfg #(.CLK_DIV(2), .DATA_BITS(9), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u4 (
        .clk(clk), .reset(reset), .tx_valid(tx_valid[4]), .tx_data(tx_data[4]),
        .tx_ready(tx_ready[4]), .txd(txd[4]), .tx_busy(tx_busy[4]), .tx_done(tx_done[4]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Line levels of a whole frame, one entry per serial bit, from the word alone.
    function automatic void build(input int i, input logic [8:0] w,
                                  output logic [15:0] fb, output int nb);
        int ones;
        ones = 0;
        fb   = '1;
        fb[0] = 1'b0;
        nb   = 1 + P_DB[i] + P_PE[i] + P_SB[i];
        for (int j = 0; j < P_DB[i]; j++) begin
            fb[1+j] = w[j];
            ones += int'(w[j]);
        end
        if (P_PE[i] != 0) fb[1+P_DB[i]] = ((ones % 2) == 1) ? (P_ODD[i] == 0) : (P_ODD[i] != 0);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input int i, input string tag);
        check($sformatf("u%0d_%s_txd", i, tag), 32'(txd[i]), 32'd1);
        check($sformatf("u%0d_%s_busy", i, tag), 32'(tx_busy[i]), 32'd0);
        check($sformatf("u%0d_%s_ready", i, tag), 32'(tx_ready[i]), 32'd1);
        check($sformatf("u%0d_%s_done", i, tag), 32'(tx_done[i]), 32'd0);
    endtask

    // Send w; while busy, tx_data and tx_valid are scrambled and must be ignored.
    // In the last in-frame cycle the inputs are set to (nv, nw) for a possible back-to-back word.
    task automatic run_frame(input int i, input logic [8:0] w, input bit nv, input logic [8:0] nw);
        logic [15:0] fb;
        int nb, f;
        build(i, w, fb, nb);
        f = nb * P_DIV[i];
        check($sformatf("u%0d_ready_pre", i), 32'(tx_ready[i]), 32'd1);
        tx_valid[i] = 1'b1;
        tx_data[i]  = w;
        for (int k = 0; k < f; k++) begin
            step();
            check($sformatf("u%0d_w%0h_txd_c%0d", i, w, k), 32'(txd[i]), 32'(fb[k / P_DIV[i]]));
            check($sformatf("u%0d_busy_c%0d", i, k), 32'(tx_busy[i]), 32'd1);
            check($sformatf("u%0d_ready_c%0d", i, k), 32'(tx_ready[i]), 32'd0);
            check($sformatf("u%0d_done_c%0d", i, k), 32'(tx_done[i]), 32'd0);
            if (k == f - 1) begin
                tx_valid[i] = nv;
                tx_data[i]  = nw;
            end else begin
                tx_valid[i] = 1'($urandom_range(0, 1));
                tx_data[i]  = 9'($urandom);
            end
        end
        step();
        check($sformatf("u%0d_done_end", i), 32'(tx_done[i]), 32'd1);
        check($sformatf("u%0d_busy_end", i), 32'(tx_busy[i]), 32'd0);
        check($sformatf("u%0d_ready_end", i), 32'(tx_ready[i]), 32'd1);
        check($sformatf("u%0d_txd_end", i), 32'(txd[i]), 32'd1);
    endtask

    task automatic idle(input int i, input int n);
        tx_valid[i] = 1'b0;
        for (int k = 0; k < n; k++) begin
            step();
            check_idle(i, "idle");
        end
    endtask

    // Start a frame and assert reset for one edge after kab in-frame cycles.
    task automatic abort_frame(input int i, input logic [8:0] w, input int kab);
        logic [15:0] fb;
        int nb;
        build(i, w, fb, nb);
        tx_valid[i] = 1'b1;
        tx_data[i]  = w;
        for (int k = 0; k < kab; k++) begin
            step();
            tx_valid[i] = 1'b0;
            check($sformatf("u%0d_abort_txd_c%0d", i, k), 32'(txd[i]), 32'(fb[k / P_DIV[i]]));
        end
        reset = 1'b1;
        step();
        check($sformatf("u%0d_abort_txd", i), 32'(txd[i]), 32'd1);
        check($sformatf("u%0d_abort_busy", i), 32'(tx_busy[i]), 32'd0);
        check($sformatf("u%0d_abort_done", i), 32'(tx_done[i]), 32'd0);
        check($sformatf("u%0d_abort_ready_in_rst", i), 32'(tx_ready[i]), 32'd0);
        reset = 1'b0;
        #1;
        check($sformatf("u%0d_abort_ready", i), 32'(tx_ready[i]), 32'd1);
        idle(i, 3);
    endtask

    initial begin
        logic [8:0] w, nw;
        bit nv;
        reset = 1'b1;
        for (int i = 0; i < N; i++) begin
            tx_valid[i] = 1'b0;
            tx_data[i]  = '0;
        end
        repeat (3) step();
        for (int i = 0; i < N; i++) begin
            check($sformatf("u%0d_rst_txd", i), 32'(txd[i]), 32'd1);
            check($sformatf("u%0d_rst_busy", i), 32'(tx_busy[i]), 32'd0);
            check($sformatf("u%0d_rst_done", i), 32'(tx_done[i]), 32'd0);
            check($sformatf("u%0d_rst_ready", i), 32'(tx_ready[i]), 32'd0);
        end
        reset = 1'b0;
        #1;
        for (int i = 0; i < N; i++) check_idle(i, "post_rst");

        // Directed frames: 8N1 0xA5, even/odd parity on 0x07, 7N2 0x7F, 9-bit at CLK_DIV=2.
        run_frame(0, 9'h0A5, 1'b0, 9'h000);
        idle(0, 3);
        run_frame(1, 9'h007, 1'b0, 9'h000);
        idle(1, 2);
        run_frame(2, 9'h007, 1'b0, 9'h000);
        idle(2, 2);
        run_frame(3, 9'h07F, 1'b0, 9'h000);
        idle(3, 2);
        run_frame(4, 9'h1A5, 1'b0, 9'h000);
        idle(4, 2);

        // Back-to-back words with tx_valid held through the done cycle.
        run_frame(0, 9'h011, 1'b1, 9'h022);
        run_frame(0, 9'h022, 1'b0, 9'h000);
        idle(0, 3);

        // Reset during data bit 3, then a clean frame.
        abort_frame(0, 9'h0C3, 4 * P_DIV[0] + 1);
        run_frame(0, 9'h03C, 1'b0, 9'h000);
        idle(0, 2);

        // Random words, randomly back-to-back, on every configuration.
        for (int i = 0; i < N; i++) begin
            w = 9'($urandom);
            for (int n = 0; n < 6; n++) begin
                nv = (n < 5) ? 1'($urandom_range(0, 1)) : 1'b0;
                nw = 9'($urandom);
                run_frame(i, w, nv, nw);
                if (!nv) idle(i, 1 + int'($urandom_range(0, 2)));
                w = nw;
            end
            idle(i, 2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
